// File: rtl/instr_mem_pipe.sv
// Instruction memory for the MiniSoc fetch port: req/gnt handshake with wait states,
// a fixed-latency read pipeline with range/alignment error reporting, and a loader write port.
module instr_mem_pipe #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int LATENCY      = 1,
  parameter int WAIT_STATES  = 0,
  parameter bit STRICT_ALIGN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [2:0]    wait_cnt;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] ld_idx;
  logic          rd_in_range;
  logic          rd_misalign;
  logic          rd_err;
  logic [31:0]   rd_word;
  logic          ld_in_range;
  logic          unused_ld_lsb;

  logic          vld_p  [LATENCY];
  logic [31:0]   data_p [LATENCY];
  logic          err_p  [LATENCY];

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == WS) ? v : v + 3'd1;
  endfunction

  // Upper index bits must be zero: an index past the end never aliases onto a low word.
  assign rd_idx      = instr_addr_i[AW+1:2];
  assign rd_in_range = (instr_addr_i[31:AW+2] == '0);
  assign rd_misalign = STRICT_ALIGN && (instr_addr_i[1:0] != 2'b00);
  assign rd_err      = !rd_in_range || rd_misalign;
  assign rd_word     = rd_err ? 32'h0 : mem[rd_idx];

  assign ld_idx        = load_addr_i[AW+1:2];
  assign ld_in_range   = (load_addr_i[31:AW+2] == '0);
  assign unused_ld_lsb = ^load_addr_i[1:0];

  assign instr_gnt_o = instr_req_i && !load_we_i && !rst && (wait_cnt == WS);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 3'd0;
    end else if (!instr_req_i || instr_gnt_o) begin
      wait_cnt <= 3'd0;
    end else begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (load_we_i && ld_in_range) begin
      mem[ld_idx] <= load_wdata_i;
    end
  end

  // Stage 0 captures the read at the grant edge; later stages shift toward the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= instr_gnt_o;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Data only advances behind a valid entry, so the last stage holds the last response.
  always_ff @(posedge clk) begin
    if (instr_gnt_o) begin
      data_p[0] <= rd_word;
      err_p[0]  <= rd_err;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (vld_p[i-1]) begin
        data_p[i] <= data_p[i-1];
        err_p[i]  <= err_p[i-1];
      end
    end
    if (rst) begin
      data_p[LATENCY-1] <= 32'h0;
      err_p[LATENCY-1]  <= 1'b0;
    end
  end

  assign instr_rvalid_o = vld_p[LATENCY-1];
  assign instr_rdata_o  = data_p[LATENCY-1];
  assign instr_err_o    = err_p[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: two configurations checked every cycle against a queue-based
// reference model, plus directed reads with hand-computed expectations.
module tb_instr_mem_pipe;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [31:0] laddr  [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        errs   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, k, $time, act, exp);
    end
  endfunction

  // Instance 0: 16 words, latency 1, no wait states, relaxed alignment.
  // Instance 1: 32 words, latency 4, two wait states, strict alignment.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DEP = (g == 0) ? 16 : 32;
    localparam int LAT = (g == 0) ? 1 : 4;
    localparam int WS  = (g == 0) ? 0 : 2;
    localparam bit SA  = (g == 0) ? 1'b0 : 1'b1;

    instr_mem_pipe #(
      .DEPTH_WORDS(DEP), .LATENCY(LAT), .WAIT_STATES(WS), .STRICT_ALIGN(SA)
    ) u_dut (
      .clk(clk), .rst(rst),
      .instr_req_i(req[g]), .instr_addr_i(addr[g]), .instr_gnt_o(gnt[g]),
      .instr_rvalid_o(rvalid[g]), .instr_rdata_o(rdata[g]), .instr_err_o(errs[g]),
      .load_we_i(we[g]), .load_addr_i(laddr[g]), .load_wdata_i(wdata[g])
    );

    logic [31:0] mm [DEP];
    resp_t       q [$];
    int          held    = 0;
    int          cyc     = 0;
    bit          started = 1'b0;
    logic [31:0] last_d  = 32'h0;
    logic        last_e  = 1'b0;

    always @(negedge clk) begin
      resp_t r;
      bit    eg;
      bit    ev;
      bit    e;
      if (started) begin
        eg = req[g] && !we[g] && !rst && (held >= WS);
        chk("gnt", g, 32'(gnt[g]), 32'(eg));
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("rvalid", g, 32'(rvalid[g]), 32'(ev));
        if (ev) begin
          last_d = q[0].d;
          last_e = q[0].e;
          void'(q.pop_front());
        end
        chk("rdata", g, rdata[g], last_d);
        chk("err", g, 32'(errs[g]), 32'(last_e));
        if (eg) begin
          e = ((addr[g] >> 2) >= DEP) || (SA && (addr[g] % 4 != 0));
          r.due = cyc + LAT;
          r.e   = e;
          r.d   = e ? 32'h0 : mm[int'(addr[g] >> 2)];
          q.push_back(r);
        end
        if (we[g] && ((laddr[g] >> 2) < DEP)) mm[int'(laddr[g] >> 2)] = wdata[g];
        if (!req[g] || eg || rst) held = 0;
        else if (held < WS) held++;
      end
      if (rst) begin
        started = 1'b1;
        q.delete();
        held   = 0;
        last_d = 32'h0;
        last_e = 1'b0;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    we[k] = 1'b1;
    laddr[k] = a;
    wdata[k] = d;
    tick();
    we[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [31:0] a, output int waits, output int lat,
                         output logic [31:0] d, output logic e);
    bit got;
    got = 1'b0;
    waits = 0;
    lat = 0;
    d = 32'hx;
    e = 1'bx;
    req[k] = 1'b1;
    addr[k] = a;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt[k]) got = 1'b1;
      else waits++;
      tick();
    end
    req[k] = 1'b0;
    chk("grant_seen", k, 32'(got), 32'd1);
    if (!got) return;
    for (int m = 1; m <= 20 && lat == 0; m++) begin
      @(negedge clk);
      if (rvalid[k]) begin
        lat = m;
        d = rdata[k];
        e = errs[k];
      end
      tick();
    end
  endtask

  logic [31:0] lit [4];
  bit          gs  [2];

  initial begin
    int          w;
    int          l;
    logic [31:0] d;
    logic        e;
    int          dep;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = 32'h0; we[k] = 1'b0; laddr[k] = 32'h0; wdata[k] = 32'h0;
    end
    lit[0] = 32'h00B50533;
    lit[1] = 32'h00150513;
    lit[2] = 32'h00500093;
    lit[3] = 32'h002081B3;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
      chk("rst_rdata", k, rdata[k], 32'h0);
      chk("rst_err", k, 32'(errs[k]), 32'd0);
    end
    tick();

    for (int i = 0; i < 32; i++) begin
      we[0] = (i < 16); laddr[0] = 32'(i * 4); wdata[0] = $urandom;
      we[1] = 1'b1;     laddr[1] = 32'(i * 4); wdata[1] = $urandom;
      tick();
    end
    we[0] = 1'b0;
    we[1] = 1'b0;

    // Back-to-back fetch on the zero-wait, single-cycle configuration.
    for (int i = 0; i < 4; i++) load(0, 32'(i * 4), lit[i]);
    req[0] = 1'b1;
    addr[0] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) chk("b2b_gnt", 0, 32'(gnt[0]), 32'd1);
      if (c >= 1) begin
        chk("b2b_rvalid", 0, 32'(rvalid[0]), 32'd1);
        chk("b2b_rdata", 0, rdata[0], lit[c-1]);
        chk("b2b_err", 0, 32'(errs[0]), 32'd0);
      end
      tick();
      if (c < 3) addr[0] = 32'((c + 1) * 4);
      else req[0] = 1'b0;
    end

    // Loader write blocks the pending grant for one cycle.
    req[0] = 1'b1; addr[0] = 32'h8;
    we[0] = 1'b1; laddr[0] = 32'h8; wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("coll_gnt_blocked", 0, 32'(gnt[0]), 32'd0);
    tick();
    we[0] = 1'b0;
    @(negedge clk);
    chk("coll_gnt", 0, 32'(gnt[0]), 32'd1);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("coll_rdata", 0, rdata[0], 32'hDEADBEEF);
    tick();

    // Range edge and relaxed alignment on the 16-word instance.
    load(0, 32'h3C, 32'hCAFEF00D);
    do_read(0, 32'h40, w, l, d, e);
    chk("oor_err", 0, 32'(e), 32'd1);
    chk("oor_rdata", 0, d, 32'h0);
    do_read(0, 32'h3C, w, l, d, e);
    chk("last_word", 0, d, 32'hCAFEF00D);
    chk("last_err", 0, 32'(e), 32'd0);
    do_read(0, 32'h06, w, l, d, e);
    chk("relaxed_rdata", 0, d, lit[1]);
    chk("relaxed_err", 0, 32'(e), 32'd0);

    // Wait states and latency on the second instance.
    load(1, 32'h10, 32'h12345678);
    do_read(1, 32'h10, w, l, d, e);
    chk("ws_waits", 1, 32'(w), 32'd2);
    chk("ws_lat", 1, 32'(l), 32'd4);
    chk("ws_rdata", 1, d, 32'h12345678);
    req[1] = 1'b1; addr[1] = 32'h10;
    tick(); tick();
    req[1] = 1'b0;
    tick();
    do_read(1, 32'h10, w, l, d, e);
    chk("drop_waits", 1, 32'(w), 32'd2);
    do_read(1, 32'h06, w, l, d, e);
    chk("strict_err", 1, 32'(e), 32'd1);
    chk("strict_rdata", 1, d, 32'h0);
    do_read(1, 32'h80, w, l, d, e);
    chk("oor1_err", 1, 32'(e), 32'd1);

    // Reset while a response is in flight drops it and clears the outputs.
    do_read(1, 32'h10, w, l, d, e);
    req[1] = 1'b1; addr[1] = 32'h10;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (gnt[1]) break;
      tick();
    end
    chk("pre_rst_gnt", 1, 32'(gnt[1]), 32'd1);
    tick();
    req[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flush_rvalid", 1, 32'(rvalid[1]), 32'd0);
      chk("flush_rdata", 1, rdata[1], 32'h0);
      tick();
    end
    do_read(1, 32'h10, w, l, d, e);
    chk("post_rst_rdata", 1, d, 32'h12345678);
    chk("post_rst_lat", 1, 32'(l), 32'd4);

    // Randomized traffic; the per-cycle model checks everything.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gs[0] = gnt[0];
      gs[1] = gnt[1];
      tick();
      rst = ($urandom % 250 == 0);
      for (int k = 0; k < 2; k++) begin
        dep = (k == 0) ? 16 : 32;
        we[k] = ($urandom % 8 == 0);
        laddr[k] = 32'(($urandom % (dep + 4)) * 4 + ($urandom % 4));
        wdata[k] = $urandom;
        if (req[k] && !gs[k]) begin
          if ($urandom % 10 == 0) req[k] = 1'b0;
        end else begin
          req[k] = ($urandom % 4 != 0);
          case ($urandom % 8)
            0: addr[k] = $urandom;
            1: addr[k] = 32'((dep + ($urandom % 16)) * 4);
            2: addr[k] = 32'(($urandom % dep) * 4 + 1 + ($urandom % 3));
            default: addr[k] = 32'(($urandom % dep) * 4);
          endcase
        end
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
      we[k] = 1'b0;
    end
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
